obf_seq_ctrl: RTL
=================

Name: obf_seq_ctrl

Overview:
- Sequencer in front of the obfuscation substitution LUT, between the IGU (index generation) and the decode stage.
- Accepts one original instruction plus its IGU index and key, then steps the LUT pointer offset (ppc) through the substitution sequence.
- Emits one (sub, imm) micro-op per step with a valid/ready handshake, and stalls upstream while a sequence is in flight.
- Index 0 bypasses the LUT and forwards the original instruction unchanged.

Parameters:
- MAX_STEPS, 16: maximum micro-ops per sequence before forced abort; range 1..2^(OBF_PPC_WIDTH-1).
- LAST_BIT, 15: bit of the LUT sub word that flags the final micro-op of a sequence.
- PPC_STRIDE, 2: ppc increment per micro-op (one sub word plus one imm word per step).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  controller can accept an instruction.
- in_index  in  OBF_IGU_WIDTH  substitution index from IGU.
- in_key  in  OBF_KEY_WIDTH  obfuscation key.
- in_insn  in  32  original instruction (bypass payload).
- lut_index  out  OBF_IGU_WIDTH  index driven to LUT.
- lut_ppc  out  OBF_PPC_WIDTH  sequence offset driven to LUT.
- lut_key  out  OBF_KEY_WIDTH  key driven to LUT.
- lut_sub  in  OBF_LUT_OUT_WIDTH  LUT sub word (combinational from lut_*).
- lut_imm  in  OBF_LUT_OUT_WIDTH  LUT imm word.
- out_valid  out  1  micro-op valid.
- out_ready  in  1  downstream accepts micro-op.
- out_sub  out  OBF_LUT_OUT_WIDTH  registered sub word.
- out_imm  out  OBF_LUT_OUT_WIDTH  registered imm word.
- out_insn  out  32  registered original instruction; meaningful when out_bypass=1.
- out_bypass  out  1  micro-op is an unmodified instruction.
- out_last  out  1  final micro-op of the current instruction.
- abort  out  1  one-cycle pulse: sequence truncated by MAX_STEPS.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: waiting for an instruction.
  - SEQ: stepping through a substitution sequence.
- Reset values (rst=1 at a clk edge): state=IDLE; ppc=0; step count=0; all out_* =0; abort=0; busy=0; lut_index=0; lut_key=0. Reset mid-sequence discards it with no further micro-ops.
- Output slot: a single register. It is free when out_valid=0 or out_ready=1. A transfer happens on out_valid&&out_ready.
- in_ready = (state==IDLE) && slot free. An instruction is accepted on in_valid&&in_ready.
- Accept with in_index==0 (bypass):
  - Next cycle: out_valid=1, out_insn=in_insn, out_bypass=1, out_last=1, out_sub=out_imm=0.
  - State stays IDLE. Latency is 1 cycle.
- Accept with in_index!=0:
  - Latch index and key; ppc=0; step=0; state->SEQ.
  - No output in the accept cycle.
- SEQ:
  - lut_ppc=ppc_q; lut_index and lut_key come from the latched values.
  - When the slot is free, load out_sub=lut_sub and out_imm=lut_imm, with out_bypass=0.
  - On each load: ppc += PPC_STRIDE (wraps modulo 2^OBF_PPC_WIDTH, not expected in a legal LUT); step += 1.
  - On the load where lut_sub[LAST_BIT]=1: set out_last=1 and go to IDLE.
  - On the load where step==MAX_STEPS-1 and LAST_BIT=0: set out_last=1, pulse abort for one cycle, and go to IDLE.
  - When the slot is not free, hold ppc, step and the output register unchanged.
- First micro-op appears 2 cycles after accept. Throughput is 1 micro-op per cycle with out_ready=1.
- Sequence-end and new-accept timing: in_ready is 0 throughout SEQ. It can rise in the cycle after the return to IDLE if the last micro-op has been taken or out_ready=1, so back-to-back instructions are separated by at least one cycle.
- When IDLE and in_index==0: lut_index and lut_key hold their last values and lut_ppc=0.
- busy=1 exactly while state==SEQ.

Optional Feature:
- Macro: OBF_SEQ_PERF_EN.
- With the macro defined, add two outputs:
  - perf_insn (32 bits): counts accepted non-bypass instructions.
  - perf_uops (32 bits): counts transferred non-bypass micro-ops.
  - Both reset to 0 on rst and wrap at 2^32.
- Without the macro: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Bypass: in_index=0, in_insn=0x15000000, out_ready=1 -> next cycle out_valid=1, out_bypass=1, out_last=1, out_insn=0x15000000; busy stays 0.
- 3-step sequence: LUT model returns LAST_BIT=1 at ppc=4, in_index=27 -> lut_ppc steps 0,2,4; three micro-ops in consecutive cycles, the first 2 cycles after accept; out_last only on the third; in_ready returns to 1 afterwards.
- Backpressure: the same 3-step sequence with out_ready low for 3 cycles after the first micro-op -> out_sub/out_imm and lut_ppc=2 held stable; no micro-op lost or duplicated.
- Abort: MAX_STEPS=4 and a LUT with no LAST_BIT set -> exactly 4 micro-ops; the 4th has out_last=1; abort pulses for 1 cycle; state returns to IDLE.
- Reset mid-sequence: assert rst after the 2nd micro-op of a 5-step sequence -> next cycle out_valid=0, busy=0, in_ready=1, lut_ppc=0; no further micro-ops.
- Perf counters (OBF_SEQ_PERF_EN defined): 1 bypass plus two 3-step sequences -> perf_insn=2, perf_uops=6.

Source files
------------

// File: rtl/obf_seq_ctrl.sv
// obf_seq_ctrl: steps the substitution LUT offset per instruction and emits (sub, imm) micro-ops.
// Optional perf_insn/perf_uops counters are present when OBF_SEQ_PERF_EN is defined.
module obf_seq_ctrl #(
   parameter int OBF_IGU_WIDTH     = 8,
   parameter int OBF_KEY_WIDTH     = 32,
   parameter int OBF_PPC_WIDTH     = 8,
   parameter int OBF_LUT_OUT_WIDTH = 16,
   parameter int MAX_STEPS         = 16,
   parameter int LAST_BIT          = 15,
   parameter int PPC_STRIDE        = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [OBF_IGU_WIDTH-1:0]     in_index,
   input  logic [OBF_KEY_WIDTH-1:0]     in_key,
   input  logic [31:0]                  in_insn,
   output logic [OBF_IGU_WIDTH-1:0]     lut_index,
   output logic [OBF_PPC_WIDTH-1:0]     lut_ppc,
   output logic [OBF_KEY_WIDTH-1:0]     lut_key,
   input  logic [OBF_LUT_OUT_WIDTH-1:0] lut_sub,
   input  logic [OBF_LUT_OUT_WIDTH-1:0] lut_imm,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OBF_LUT_OUT_WIDTH-1:0] out_sub,
   output logic [OBF_LUT_OUT_WIDTH-1:0] out_imm,
   output logic [31:0]                  out_insn,
   output logic                         out_bypass,
   output logic                         out_last,
   output logic                         abort,
   output logic                         busy
`ifdef OBF_SEQ_PERF_EN
   ,output logic [31:0]                 perf_insn,
   output logic [31:0]                  perf_uops
`endif
);
   typedef enum logic {IDLE, SEQ} state_t;
   localparam logic [OBF_PPC_WIDTH-1:0] STRIDE    = OBF_PPC_WIDTH'(PPC_STRIDE);
   localparam logic [OBF_PPC_WIDTH-1:0] STEP_LAST = OBF_PPC_WIDTH'(MAX_STEPS - 1);
   state_t                     r_state, w_state_nxt;
   logic [OBF_PPC_WIDTH-1:0]   r_ppc, r_step;
   logic [OBF_IGU_WIDTH-1:0]   r_idx;
   logic [OBF_KEY_WIDTH-1:0]   r_key;
   logic w_free, w_accept, w_seq_in, w_load, w_hit_last, w_trunc;
   assign w_free     = !out_valid || out_ready;
   assign in_ready   = (r_state == IDLE) && w_free;
   assign w_accept   = in_valid && in_ready;
   assign w_seq_in   = in_index != '0;
   assign w_load     = (r_state == SEQ) && w_free;
   assign w_hit_last = lut_sub[LAST_BIT];
   assign w_trunc    = !w_hit_last && (r_step == STEP_LAST);
   assign lut_index  = r_idx;
   assign lut_key    = r_key;
   assign lut_ppc    = (r_state == SEQ) ? r_ppc : '0;
   assign busy       = r_state == SEQ;
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == IDLE) ? ((w_accept && w_seq_in) ? SEQ : IDLE)
                                      : ((w_load && (w_hit_last || w_trunc)) ? IDLE : SEQ);
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ppc <= '0;
         r_step <= '0;
         r_idx <= '0;
         r_key <= '0;
      end else if (w_accept && w_seq_in) begin
         r_ppc <= '0;
         r_step <= '0;
         r_idx <= in_index;
         r_key <= in_key;
      end else if (w_load) begin
         r_ppc <= r_ppc + STRIDE;
         r_step <= r_step + 1'b1;
      end
   end
   // Single output slot: bypass and LUT loads only happen when it is free.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sub <= '0;
         out_imm <= '0;
         out_insn <= '0;
         out_bypass <= 1'b0;
         out_last <= 1'b0;
         abort <= 1'b0;
      end else begin
         abort <= w_load && w_trunc;
         if (w_accept && !w_seq_in) begin
            out_valid <= 1'b1;
            out_sub <= '0;
            out_imm <= '0;
            out_insn <= in_insn;
            out_bypass <= 1'b1;
            out_last <= 1'b1;
         end else if (w_load) begin
            out_valid <= 1'b1;
            out_sub <= lut_sub;
            out_imm <= lut_imm;
            out_bypass <= 1'b0;
            out_last <= w_hit_last || w_trunc;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
`ifdef OBF_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_insn <= '0;
         perf_uops <= '0;
      end else begin
         if (w_accept && w_seq_in) perf_insn <= perf_insn + 1'b1;
         if (out_valid && out_ready && !out_bypass) perf_uops <= perf_uops + 1'b1;
      end
   end
`endif
endmodule
